// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register command sequencer.
// FSM state encoding, command-byte field positions and byte/address widths.
package spi_reg_pkg;

    localparam int CMD_RW_BIT = 7;
    localparam int SPI_ADDR_W = 7;
    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WDATA = 3'd2,
        RREQ  = 3'd3,
        RCAP  = 3'd4,
        RLOAD = 3'd5,
        RWAIT = 3'd6
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser followed by a one-cycle rise/fall pulse generator.
// RST_VAL sets the idle level of the input so reset never produces an edge.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI frame to register-bank sequencer.
// First byte of a frame is command/address (bit7=1 read), following bytes are
// write data or read slots. Optional macro SPI_REG_CTRL_AUTOINC_EN makes the
// address step after every data byte; without it bursts hit one address.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W = SPI_ADDR_W,
    parameter int DATA_W = SPI_BYTE_W
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst_n,
    input  logic              i_ssn,
    input  logic              i_rx_ready,
    input  logic              i_tx_ready,
    input  logic [DATA_W-1:0] i_rx_data,
    output logic              o_csn,
    output logic              o_wr,
    output logic              o_rd,
    output logic [DATA_W-1:0] o_tx_data,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [DATA_W-1:0] o_reg_wdata,
    output logic              o_reg_we,
    output logic              o_reg_re,
    input  logic [DATA_W-1:0] i_reg_rdata,
    output logic              o_busy,
    output logic              o_abort,
    output logic              o_ovr_err
);

    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
`ifdef SPI_REG_CTRL_AUTOINC_EN
        return a + {{(ADDR_W-1){1'b0}}, 1'b1};
`else
        return a;
`endif
    endfunction

    logic ssn_s, ssn_rise_s, ssn_fall_s;
    logic rx_sync_s, rx_rise_s, rx_fall_s;
    logic rx_ev_s;
    logic rd_busy_s;
    logic unused_s;

    spi_sync_edge #(.RST_VAL(1'b1)) u_ssn_sync (
        .clk_i   (i_sys_clk),
        .rst_n_i (i_sys_rst_n),
        .async_i (i_ssn),
        .sync_o  (ssn_s),
        .rise_o  (ssn_rise_s),
        .fall_o  (ssn_fall_s)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_rx_sync (
        .clk_i   (i_sys_clk),
        .rst_n_i (i_sys_rst_n),
        .async_i (i_rx_ready),
        .sync_o  (rx_sync_s),
        .rise_o  (rx_rise_s),
        .fall_o  (rx_fall_s)
    );

    assign unused_s = rx_sync_s ^ rx_fall_s;

    // A byte counts if ssn was still low when it landed; this lets a byte that
    // coincides with the ssn rising edge be processed before the frame closes.
    assign rx_ev_s   = rx_rise_s & (~ssn_s | ssn_rise_s);
    assign rd_busy_s = 1'b0;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                csn_q, csn_d;
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                re_q, re_d;
    logic                busy_q, busy_d;
    logic                abort_q, abort_d;
    logic                ovr_q, ovr_d;

    // Next-state and registered-output decode for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        csn_d      = csn_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        tx_d       = tx_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        busy_d     = busy_q;
        abort_d    = 1'b0;
        ovr_d      = ovr_q;

        case (state_q)
            IDLE: begin
                csn_d  = 1'b1;
                busy_d = 1'b0;
                if (ssn_fall_s) begin
                    csn_d   = 1'b0;
                    busy_d  = 1'b1;
                    ovr_d   = 1'b0;
                    state_d = CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            CMD: begin
                if (rx_ev_s) begin
                    rd_d   = 1'b1;
                    addr_d = i_rx_data[ADDR_W-1:0];
                    if (i_rx_data[CMD_RW_BIT]) begin
                        // Read request is issued on entry so rdata lands in RCAP.
                        re_d       = 1'b1;
                        reg_addr_d = i_rx_data[ADDR_W-1:0];
                        state_d    = RREQ;
                    end else begin
                        state_d = WDATA;
                    end
                end else begin
                    state_d = CMD;
                end
            end
            WDATA: begin
                if (rx_ev_s) begin
                    rd_d       = 1'b1;
                    we_d       = 1'b1;
                    wdata_d    = i_rx_data;
                    reg_addr_d = addr_q;
                    addr_d     = addr_next(addr_q);
                end else begin
                    state_d = WDATA;
                end
            end
            RREQ: begin
                if (rx_ev_s) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
                state_d = RCAP;
            end
            RCAP: begin
                tx_d = i_reg_rdata;
                if (rx_ev_s) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
                state_d = RLOAD;
            end
            RLOAD: begin
                if (rx_ev_s) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
                if (i_tx_ready) begin
                    wr_d    = 1'b1;
                    addr_d  = addr_next(addr_q);
                    state_d = RWAIT;
                end else begin
                    state_d = RLOAD;
                end
            end
            RWAIT: begin
                if (rx_ev_s) begin
                    rd_d       = 1'b1;
                    re_d       = 1'b1;
                    reg_addr_d = addr_q;
                    state_d    = RREQ;
                end else begin
                    state_d = RWAIT;
                end
            end
            default: begin
                state_d = IDLE;
                csn_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Frame end overrides the state decode unless a byte is being taken now.
        if ((state_q != IDLE) && ssn_s && !rx_ev_s) begin
            state_d = IDLE;
            csn_d   = 1'b1;
            busy_d  = 1'b0;
            wr_d    = 1'b0;
            re_d    = 1'b0;
            abort_d = (state_q == RREQ) || (state_q == RCAP) || (state_q == RLOAD)
                      || rd_busy_s;
        end else begin
            abort_d = 1'b0;
        end
    end

    // State and output registers; async reset returns every output to idle.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q    <= IDLE;
            addr_q     <= {ADDR_W{1'b0}};
            csn_q      <= 1'b1;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            tx_q       <= {DATA_W{1'b0}};
            reg_addr_q <= {ADDR_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            busy_q     <= 1'b0;
            abort_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            csn_q      <= csn_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            tx_q       <= tx_d;
            reg_addr_q <= reg_addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            busy_q     <= busy_d;
            abort_q    <= abort_d;
            ovr_q      <= ovr_d;
        end
    end

    assign o_csn       = csn_q;
    assign o_wr        = wr_q;
    assign o_rd        = rd_q;
    assign o_tx_data   = tx_q;
    assign o_reg_addr  = reg_addr_q;
    assign o_reg_wdata = wdata_q;
    assign o_reg_we    = we_q;
    assign o_reg_re    = re_q;
    assign o_busy      = busy_q;
    assign o_abort     = abort_q;
    assign o_ovr_err   = ovr_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: stimulus tasks push expected register
// writes, reads, transmit loads and aborts; a negedge monitor pops and checks.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ssn = 1'b1;
    logic       rx_ready = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       csn, wr, rd, reg_we, reg_re, busy, abort_p, ovr;
    logic [7:0] tx_data, reg_wdata;
    logic [6:0] reg_addr;
    logic [7:0] reg_rdata = 8'h00;

    always #5 clk = ~clk;

    spi_reg_ctrl dut (
        .i_sys_clk   (clk),
        .i_sys_rst_n (rst_n),
        .i_ssn       (ssn),
        .i_rx_ready  (rx_ready),
        .i_tx_ready  (tx_ready),
        .i_rx_data   (rx_data),
        .o_csn       (csn),
        .o_wr        (wr),
        .o_rd        (rd),
        .o_tx_data   (tx_data),
        .o_reg_addr  (reg_addr),
        .o_reg_wdata (reg_wdata),
        .o_reg_we    (reg_we),
        .o_reg_re    (reg_re),
        .i_reg_rdata (reg_rdata),
        .o_busy      (busy),
        .o_abort     (abort_p),
        .o_ovr_err   (ovr)
    );

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr_q[$];
    logic [6:0] exp_re_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] wbuf[$];
    logic [7:0] model_mem [128];
    logic [7:0] seed_mem  [128];
    logic [7:0] bank_mem  [128];
    logic       load_bank = 1'b0;
    int checks = 0, failures = 0;
    int exp_rd = 0, seen_rd = 0, exp_abort = 0, seen_abort = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] nxt(input logic [6:0] a);
`ifdef SPI_REG_CTRL_AUTOINC_EN
        return 7'((int'(a) + 1) % 128);
`else
        return a;
`endif
    endfunction

    // Register bank: registered read data one cycle after the read strobe.
    always @(posedge clk) begin
        if (load_bank) begin
            for (int i = 0; i < 128; i++) bank_mem[i] <= seed_mem[i];
        end else begin
            if (reg_we) bank_mem[reg_addr] <= reg_wdata;
            if (reg_re) reg_rdata <= bank_mem[reg_addr];
        end
    end

    // Monitor: every DUT strobe is matched against the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_we) begin
                if (exp_wr_q.size() == 0) chk("unexpected_we", 32'd1, 32'd0);
                else begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    chk("we_addr", 32'(reg_addr), 32'(e.a));
                    chk("we_data", 32'(reg_wdata), 32'(e.d));
                end
            end
            if (reg_re) begin
                if (exp_re_q.size() == 0) chk("unexpected_re", 32'd1, 32'd0);
                else chk("re_addr", 32'(reg_addr), 32'(exp_re_q.pop_front()));
            end
            if (wr) begin
                if (exp_tx_q.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
                else chk("tx_data", 32'(tx_data), 32'(exp_tx_q.pop_front()));
            end
            if (rd) seen_rd++;
            if (abort_p) seen_abort++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        ssn = 1'b0;
        tick(6);
    endtask

    task automatic frame_end();
        ssn = 1'b1;
        tick(6);
        chk("csn_after_frame", 32'(csn), 32'd1);
        chk("busy_after_frame", 32'(busy), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick(2);
        rx_ready = 1'b0;
        tick(12);
    endtask

    // Write frame using the bytes queued in wbuf.
    task automatic write_frame(input logic [6:0] addr);
        logic [6:0] a;
        a = addr;
        frame_start();
        send_byte({1'b0, addr});
        exp_rd++;
        chk("busy_mid_frame", 32'(busy), 32'd1);
        chk("csn_mid_frame", 32'(csn), 32'd0);
        foreach (wbuf[i]) begin
            exp_wr_q.push_back('{a: a, d: wbuf[i]});
            model_mem[a] = wbuf[i];
            send_byte(wbuf[i]);
            exp_rd++;
            a = nxt(a);
        end
        frame_end();
    endtask

    // Read frame: the command plus each dummy byte triggers a prefetch.
    task automatic read_frame(input logic [6:0] addr, input int n);
        logic [6:0] a;
        a = addr;
        frame_start();
        exp_re_q.push_back(a);
        exp_tx_q.push_back(model_mem[a]);
        send_byte({1'b1, addr});
        exp_rd++;
        for (int i = 0; i < n; i++) begin
            a = nxt(a);
            exp_re_q.push_back(a);
            exp_tx_q.push_back(model_mem[a]);
            send_byte(8'($urandom));
            exp_rd++;
        end
        frame_end();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            seed_mem[i]  = 8'($urandom);
            model_mem[i] = seed_mem[i];
        end
        seed_mem[3]  = 8'h3C;
        model_mem[3] = 8'h3C;
        load_bank = 1'b1;
        tick(2);
        load_bank = 1'b0;
        chk("rst_ctrl_bits", 32'({csn, wr, rd, reg_we, reg_re, abort_p, busy, ovr}), 32'h80);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // Single write.
        wbuf = '{8'hA5};
        write_frame(7'h05);
        // Burst with address wrap when incrementing.
        wbuf = '{8'h11, 8'h22, 8'h33};
        write_frame(7'h7E);
        // Read of a known value.
        read_frame(7'h03, 1);

        // Abort: transmitter never ready, frame closes in RLOAD.
        tx_ready = 1'b0;
        frame_start();
        exp_re_q.push_back(7'h20);
        exp_abort++;
        send_byte(8'hA0);
        exp_rd++;
        frame_end();
        chk("abort_count", 32'(seen_abort), 32'(exp_abort));
        tx_ready = 1'b1;

        // Overrun: second byte lands two cycles after a read command.
        frame_start();
        exp_re_q.push_back(7'h11);
        exp_tx_q.push_back(model_mem[7'h11]);
        rx_data  = 8'h91;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(12);
        exp_rd++;
        chk("ovr_set", 32'(ovr), 32'd1);
        frame_end();
        chk("ovr_held", 32'(ovr), 32'd1);
        frame_start();
        chk("ovr_cleared", 32'(ovr), 32'd0);
        frame_end();

        // Randomised frames.
        for (int k = 0; k < 24; k++) begin
            logic [6:0] ra;
            int n;
            ra = 7'($urandom_range(0, 127));
            n  = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 0) begin
                wbuf.delete();
                for (int j = 0; j < n; j++) wbuf.push_back(8'($urandom));
                write_frame(ra);
            end else begin
                read_frame(ra, n - 1);
            end
        end

        // Reset asserted in the cycle the data byte is detected.
        frame_start();
        send_byte(8'h10);
        exp_rd++;
        rx_data  = 8'h55;
        rx_ready = 1'b1;
        tick(2);
        rst_n    = 1'b0;
        ssn      = 1'b1;
        rx_ready = 1'b0;
        #1;
        chk("midrst_ctrl_bits", 32'({csn, wr, rd, reg_we, reg_re, abort_p, busy, ovr}), 32'h80);
        chk("midrst_reg_wdata", 32'(reg_wdata), 32'd0);
        chk("midrst_reg_addr", 32'(reg_addr), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        chk("post_rst_csn", 32'(csn), 32'd1);

        chk("pending_writes", 32'(exp_wr_q.size()), 32'd0);
        chk("pending_reads", 32'(exp_re_q.size()), 32'd0);
        chk("pending_tx", 32'(exp_tx_q.size()), 32'd0);
        chk("rd_strobes", 32'(seen_rd), 32'(exp_rd));
        chk("abort_total", 32'(seen_abort), 32'(exp_abort));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
